// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - width encodings, FSM states and lane helpers shared by the dcache responder
package dcache_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_REFILL,
        S_RESP,
        S_WRITE
    } state_t;

    // Pick the addressed byte/half out of a word and extend it; width 11 behaves as a word.
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] width,
                                                input logic [1:0] offset, input logic ext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (width)
            W_BYTE:  return {{24{~ext & b[7]}}, b};
            W_HALF:  return {{16{~ext & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] offset);
        case (width)
            W_BYTE:  return 4'b0001 << offset;
            W_HALF:  return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data into every lane so the byte enables select it.
    function automatic logic [31:0] store_lanes(input logic [31:0] data, input logic [1:0] width);
        case (width)
            W_BYTE:  return {4{data[7:0]}};
            W_HALF:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// rtl/dcache_line_ram.sv - cache data array with async read and byte-enabled write
module dcache_line_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-through dcache responder; DCACHE_MISALIGN_CHECK_EN adds a misalign flag
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_ena,
    input  logic        w_ena,
    input  logic        ext,
    input  logic [1:0]  width,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic        valid,
    output logic [31:0] data_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_MISALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 30 - WB - IB;

    state_t        state;
    logic [31:0]   cap_addr;
    logic [1:0]    cap_width;
    logic          cap_ext;
    logic [WB-1:0] beat_cnt;

    logic [TB-1:0] tags [SETS];
    logic [SETS-1:0] line_valid;

    logic [WB-1:0] in_word, cap_word;
    logic [IB-1:0] in_index, cap_index;
    logic [TB-1:0] in_tag, cap_tag;
    logic          hit, mis, st_we, rf_we;
    logic [31:0]   ram_rdata;

    assign in_word   = addr[2 +: WB];
    assign in_index  = addr[2+WB +: IB];
    assign in_tag    = addr[31 -: TB];
    assign cap_word  = cap_addr[2 +: WB];
    assign cap_index = cap_addr[2+WB +: IB];
    assign cap_tag   = cap_addr[31 -: TB];

    assign hit = line_valid[in_index] && (tags[in_index] == in_tag);

`ifdef DCACHE_MISALIGN_CHECK_EN
    assign mis = ((width == W_HALF) && addr[0]) || (width[1] && (addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Hit stores patch the line at capture; refill beats land at the word the bus is fetching.
    assign st_we = (state == S_IDLE) && w_ena && hit && !mis;
    assign rf_we = (state == S_REFILL) && mem_ack;

    dcache_line_ram #(.AW(IB + WB)) u_ram (
        .clk   (clk),
        .we    (!rst && (st_we || rf_we)),
        .waddr (rf_we ? {cap_index, mem_addr[2 +: WB]} : {in_index, in_word}),
        .be    (rf_we ? 4'hF : lane_be(width, addr[1:0])),
        .wdata (rf_we ? mem_rdata : store_lanes(data_in, width)),
        .raddr ((state == S_IDLE) ? {in_index, in_word} : {cap_index, cap_word}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            valid      <= 1'b0;
            data_out   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            line_valid <= '0;
`ifdef DCACHE_MISALIGN_CHECK_EN
            misalign   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    valid    <= 1'b0;
                    data_out <= '0;
                    if (r_ena || w_ena) begin
                        cap_addr  <= addr;
                        cap_width <= width;
                        cap_ext   <= ext;
                        if (mis) begin
                            state    <= S_HIT;
                            valid    <= 1'b1;
`ifdef DCACHE_MISALIGN_CHECK_EN
                            misalign <= 1'b1;
`endif
                        end else if (w_ena) begin
                            state     <= S_WRITE;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= store_lanes(data_in, width);
                            mem_be    <= lane_be(width, addr[1:0]);
                        end else if (hit) begin
                            state    <= S_HIT;
                            valid    <= 1'b1;
                            data_out <= extend_load(ram_rdata, width, addr[1:0], ext);
                        end else begin
                            // Invalidate first so an interrupted refill never leaves a half-filled valid line.
                            state                <= S_REFILL;
                            line_valid[in_index] <= 1'b0;
                            beat_cnt             <= '0;
                            mem_req              <= 1'b1;
                            mem_we               <= 1'b0;
                            mem_be               <= 4'hF;
                            mem_addr             <= {addr[31:2], 2'b00};
                        end
                    end
                end
                S_HIT, S_RESP: begin
                    state    <= S_IDLE;
                    valid    <= 1'b0;
                    data_out <= '0;
`ifdef DCACHE_MISALIGN_CHECK_EN
                    misalign <= 1'b0;
`endif
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        beat_cnt             <= beat_cnt + WB'(1);
                        mem_addr[2 +: WB]    <= mem_addr[2 +: WB] + WB'(1);
                        if (&beat_cnt) begin
                            tags[cap_index]       <= cap_tag;
                            line_valid[cap_index] <= 1'b1;
                            mem_req               <= 1'b0;
                            mem_be                <= '0;
                            valid                 <= 1'b1;
                            data_out              <= extend_load(ram_rdata, cap_width, cap_addr[1:0], cap_ext);
                            state                 <= S_RESP;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_be   <= '0;
                        valid    <= 1'b1;
                        data_out <= '0;
                        state    <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - scoreboard bench for dcache_responder with a req/ack memory model
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_ena = 1'b0, w_ena = 1'b0, ext = 1'b0;
    logic [1:0]  width = 2'b10;
    logic [31:0] addr = '0, data_in = '0;
    logic        valid, mem_req, mem_we, mem_ack;
    logic [31:0] data_out, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        model_ack = 1'b0, stray_ack = 1'b0;
    logic [31:0] model_rdata = '0;
`ifdef DCACHE_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    assign mem_ack = model_ack | stray_ack;

    dcache_responder dut (
        .clk(clk), .rst(rst), .r_ena(r_ena), .w_ena(w_ena), .ext(ext), .width(width),
        .addr(addr), .data_in(data_in), .valid(valid), .data_out(data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(model_rdata)
`ifdef DCACHE_MISALIGN_CHECK_EN
        , .misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } beat_t;
    typedef struct { logic [31:0] data; logic mis; } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];
    int n_tests = 0, n_fail = 0;
    int mem_lat = 1, beats_seen = 0, last_ack_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1000) return 32'hDEADBEEF;
        return a ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic push_rd(input logic [31:0] a);
        beat_t b;
        b.addr = a; b.we = 1'b0; b.be = 4'hF; b.wdata = '0;
        beat_q.push_back(b);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        beat_t b;
        b.addr = a; b.we = 1'b1; b.be = be; b.wdata = wd;
        beat_q.push_back(b);
    endtask

    // Memory model: checks each beat against the expected queue, acks after mem_lat cycles.
    beat_t m_b;
    int    m_n;
    logic  m_alive;
    initial begin
        forever begin
            @(negedge clk);
            model_ack = 1'b0;
            if (mem_req && !rst) begin
                beats_seen++;
                if (beat_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_beat: addr %h we %b", mem_addr, mem_we);
                end else begin
                    m_b = beat_q.pop_front();
                    check("beat_addr", mem_addr, m_b.addr);
                    check("beat_we", 32'(mem_we), 32'(m_b.we));
                    check("beat_be", 32'(mem_be), 32'(m_b.be));
                    if (m_b.we) check("beat_wdata", mem_wdata & be_mask(m_b.be), m_b.wdata & be_mask(m_b.be));
                end
                m_n = 1;
                m_alive = 1'b1;
                while (m_n < mem_lat) begin
                    @(negedge clk);
                    m_n++;
                    if (!mem_req) begin
                        m_alive = 1'b0;
                        break;
                    end
                end
                if (m_alive) begin
                    model_ack    = 1'b1;
                    model_rdata  = mem_word(mem_addr);
                    last_ack_cyc = cyc;
                end
            end
        end
    end

    resp_t mon_r;
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (resp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_valid: data_out %h", data_out);
            end else begin
                mon_r = resp_q.pop_front();
                check("resp_data", data_out, mon_r.data);
`ifdef DCACHE_MISALIGN_CHECK_EN
                check("resp_misalign", 32'(misalign), 32'(mon_r.mis));
`endif
            end
        end
    end

    int valid_cyc = 0;
    task automatic do_req(input string name, input logic rd, input logic wr, input logic e,
                          input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input logic exp_mis, input int exp_lat);
        resp_t r;
        int n;
        r.data = exp_data; r.mis = exp_mis;
        resp_q.push_back(r);
        @(negedge clk);
        r_ena = rd; w_ena = wr; ext = e; width = wd; addr = a; data_in = d;
        @(negedge clk);
        r_ena = 1'b0; w_ena = 1'b0;
        n = 1;
        while (!valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(valid), 32'd1);
        if (exp_lat > 0) check({name, "_lat"}, 32'(n), 32'(exp_lat));
        valid_cyc = cyc;
    endtask

    int bs0, n;
    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid), 0);
        check("rst_data_out", data_out, 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_be", 32'(mem_be), 0);
        rst = 1'b0;

        push_rd(32'h1000); push_rd(32'h1004); push_rd(32'h1008); push_rd(32'h100C);
        do_req("lw_cold", 1, 0, 0, 2'b10, 32'h1000, 0, 32'hDEADBEEF, 0, 0);
        do_req("lw_hit",  1, 0, 0, 2'b10, 32'h1000, 0, 32'hDEADBEEF, 0, 1);
        do_req("lb_1003", 1, 0, 0, 2'b00, 32'h1003, 0, 32'hFFFFFFDE, 0, 1);
        do_req("lbu_1003",1, 0, 1, 2'b00, 32'h1003, 0, 32'h000000DE, 0, 1);
        do_req("lh_1002", 1, 0, 0, 2'b01, 32'h1002, 0, 32'hFFFFDEAD, 0, 1);
        do_req("lhu_1000",1, 0, 1, 2'b01, 32'h1000, 0, 32'h0000BEEF, 0, 1);
        do_req("lb_1000", 1, 0, 0, 2'b00, 32'h1000, 0, 32'hFFFFFFEF, 0, 1);

        push_wr(32'h1000, 4'b0010, 32'h00005500);
        do_req("sb_1001", 0, 1, 0, 2'b00, 32'h1001, 32'h55, 32'h0, 0, 0);
        do_req("lw_after_sb", 1, 0, 0, 2'b10, 32'h1000, 0, 32'hDEAD55EF, 0, 1);

        mem_lat = 3;
        push_rd(32'h2008); push_rd(32'h200C); push_rd(32'h2000); push_rd(32'h2004);
        do_req("lw_2008_lat3", 1, 0, 0, 2'b10, 32'h2008, 0, 32'h5A5A2008, 0, 0);
        check("valid_after_last_ack", 32'(valid_cyc), 32'(last_ack_cyc + 1));
        mem_lat = 1;

        push_wr(32'h5000, 4'hF, 32'h12345678);
        do_req("sw_miss", 0, 1, 0, 2'b10, 32'h5000, 32'h12345678, 32'h0, 0, 0);
        push_rd(32'h5000); push_rd(32'h5004); push_rd(32'h5008); push_rd(32'h500C);
        do_req("lw_after_sw_miss", 1, 0, 0, 2'b10, 32'h5000, 0, 32'h5A5A5000, 0, 0);
        push_wr(32'h5000, 4'b1100, 32'hABCD0000);
        do_req("sh_rw_both", 1, 1, 0, 2'b01, 32'h5002, 32'h0000ABCD, 32'h0, 0, 0);
        do_req("lw_after_sh", 1, 0, 0, 2'b10, 32'h5000, 0, 32'hABCD5000, 0, 1);
        do_req("lw_width11", 1, 0, 0, 2'b11, 32'h5000, 0, 32'hABCD5000, 0, 1);

        @(negedge clk); stray_ack = 1'b1;
        @(negedge clk); stray_ack = 1'b0;
        repeat (3) @(negedge clk);

        mem_lat = 4;
        push_rd(32'h4008); push_rd(32'h400C);
        bs0 = beats_seen;
        @(negedge clk); r_ena = 1'b1; width = 2'b10; addr = 32'h4008;
        @(negedge clk); r_ena = 1'b0;
        n = 0;
        while (beats_seen < bs0 + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("abort_second_beat", 32'(beats_seen - bs0), 32'd2);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_mem_req", 32'(mem_req), 0);
        check("abort_valid", 32'(valid), 0);
        repeat (10) @(negedge clk);
        mem_lat = 1;

        push_rd(32'h2008); push_rd(32'h200C); push_rd(32'h2000); push_rd(32'h2004);
        do_req("lw_2008_after_rst", 1, 0, 0, 2'b10, 32'h2008, 0, 32'h5A5A2008, 0, 0);
        push_rd(32'h1000); push_rd(32'h1004); push_rd(32'h1008); push_rd(32'h100C);
        do_req("lw_1000_after_rst", 1, 0, 0, 2'b10, 32'h1000, 0, 32'hDEADBEEF, 0, 0);

`ifdef DCACHE_MISALIGN_CHECK_EN
        do_req("lw_misalign", 1, 0, 0, 2'b10, 32'h1002, 0, 32'h0, 1, 1);
        do_req("lh_misalign", 1, 0, 0, 2'b01, 32'h1001, 0, 32'h0, 1, 1);
`endif

        repeat (5) @(negedge clk);
        check("beats_left", 32'(beat_q.size()), 0);
        check("resps_left", 32'(resp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
